// File: rtl/mips_cpu_pkg.sv
// Shared opcode, funct and REGIMM codes for the
// multi-cycle MIPS-I CPU and its execute datapath.
package mips_cpu_pkg;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_REGIMM  = 6'h01,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_BLEZ    = 6'h06,
    OP_BGTZ    = 6'h07,
    OP_ADDIU   = 6'h09,
    OP_SLTI    = 6'h0A,
    OP_SLTIU   = 6'h0B,
    OP_ANDI    = 6'h0C,
    OP_ORI     = 6'h0D,
    OP_XORI    = 6'h0E,
    OP_LUI     = 6'h0F,
    OP_LB      = 6'h20,
    OP_LH      = 6'h21,
    OP_LWL     = 6'h22,
    OP_LW      = 6'h23,
    OP_LBU     = 6'h24,
    OP_LHU     = 6'h25,
    OP_LWR     = 6'h26,
    OP_SB      = 6'h28,
    OP_SH      = 6'h29,
    OP_SWL     = 6'h2A,
    OP_SW      = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    F_SLL   = 6'h00,
    F_SRL   = 6'h02,
    F_SRA   = 6'h03,
    F_SLLV  = 6'h04,
    F_SRLV  = 6'h06,
    F_SRAV  = 6'h07,
    F_MTHI  = 6'h11,
    F_MTLO  = 6'h13,
    F_MULT  = 6'h18,
    F_MULTU = 6'h19,
    F_DIV   = 6'h1A,
    F_DIVU  = 6'h1B,
    F_ADD   = 6'h20,
    F_ADDU  = 6'h21,
    F_SUB   = 6'h22,
    F_SUBU  = 6'h23,
    F_AND   = 6'h24,
    F_OR    = 6'h25,
    F_XOR   = 6'h26,
    F_NOR   = 6'h27,
    F_SLT   = 6'h2A,
    F_SLTU  = 6'h2B
  } funct_t;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_cpu_divider.sv
// Restoring shift-subtract divider, one quotient bit
// per cycle; sign fix-up applied on the final step.
module mips_cpu_divider
  import mips_cpu_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        fin,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] acc;
  logic [31:0] rem;
  logic [31:0] dsr;
  logic [31:0] a_keep;
  logic        neg_q;
  logic        neg_r;
  logic        dz;

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] rem_nx;
  logic [31:0] acc_nx;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // one restoring step and operand magnitudes
  always_comb begin
    rem_sh = {rem, acc[31]};
    diff   = rem_sh - {1'b0, dsr};
    fits   = ~diff[32];
    rem_nx = fits ? diff[31:0] : rem_sh[31:0];
    acc_nx = {acc[30:0], fits};
    a_mag  = (signed_op && dividend[31]) ? -dividend : dividend;
    b_mag  = (signed_op && divisor[31]) ? -divisor : divisor;
  end

  assign fin = (state == S_RUN) && (cnt == CW'(DIV_CYCLES - 1));

  // final result with sign and divide-by-zero fix-up
  always_comb begin
    quotient  = neg_q ? -acc_nx : acc_nx;
    remainder = neg_r ? -rem_nx : rem_nx;
    if (dz) begin
      quotient  = 32'hFFFF_FFFF;
      remainder = a_keep;
    end
  end

  // divider sequencing with registered busy/done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
      dsr    <= '0;
      a_keep <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      unique case (state)
        S_RUN: begin
          acc <= acc_nx;
          rem <= rem_nx;
          cnt <= cnt + 1'b1;
          if (fin) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
          if (start) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= a_mag;
            rem    <= '0;
            dsr    <= b_mag;
            a_keep <= dividend;
            neg_q  <= signed_op & (dividend[31] ^ divisor[31]);
            neg_r  <= signed_op & dividend[31];
            dz     <= (divisor == 32'd0);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mips_cpu_exec_datapath.sv
// Execute datapath: register file, ALU/branch unit,
// HI/LO with single-cycle multiply and iterative divide.
module mips_cpu_exec_datapath
  import mips_cpu_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [4:0]  rs_idx,
  input  logic [4:0]  rt_idx,
  input  logic [4:0]  wr_idx,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] register_v0,
  input  logic        carry_in,
  output logic [31:0] alu_out,
  output logic        carry_out,
  output logic        zero,
  output logic        branch_taken,
  output logic        link,
  input  logic        hilo_en,
  input  logic        div_start,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] regs [32];

  // register file write port; r0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && wr_idx != 5'd0) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign rs_data     = (rs_idx == 5'd0) ? '0 : regs[rs_idx];
  assign rt_data     = (rt_idx == 5'd0) ? '0 : regs[rt_idx];
  assign register_v0 = regs[2];

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sx;
  logic [32:0] add_ab;
  logic [32:0] sub_ab;
  logic [32:0] add_ai;

  assign a      = rs_data;
  assign b      = rt_data;
  assign sx     = sext16(imm);
  assign add_ab = {1'b0, a} + {1'b0, b};
  assign sub_ab = {1'b0, a} + {1'b0, ~b} + 33'd1;
  assign add_ai = {1'b0, a} + {1'b0, sx};

  // ALU result, carry and branch condition
  always_comb begin
    alu_out      = '0;
    carry_out    = carry_in;
    branch_taken = 1'b0;
    link         = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          F_SLL:  alu_out = b << shamt;
          F_SRL:  alu_out = b >> shamt;
          F_SRA:  alu_out = $signed(b) >>> shamt;
          F_SLLV: alu_out = b << a[4:0];
          F_SRLV: alu_out = b >> a[4:0];
          F_SRAV: alu_out = $signed(b) >>> a[4:0];
          F_ADD, F_ADDU: begin
            alu_out   = add_ab[31:0];
            carry_out = add_ab[32];
          end
          F_SUB, F_SUBU: begin
            alu_out   = sub_ab[31:0];
            carry_out = sub_ab[32];
          end
          F_AND:  alu_out = a & b;
          F_OR:   alu_out = a | b;
          F_XOR:  alu_out = a ^ b;
          F_NOR:  alu_out = ~(a | b);
          F_SLT:  alu_out = {31'd0, $signed(a) < $signed(b)};
          F_SLTU: alu_out = {31'd0, a < b};
          default: alu_out = '0;
        endcase
      end
      OP_REGIMM: begin
        case (rt_idx)
          RT_BLTZ: branch_taken = a[31];
          RT_BGEZ: branch_taken = ~a[31];
          RT_BLTZAL: begin
            branch_taken = a[31];
            link         = 1'b1;
          end
          RT_BGEZAL: begin
            branch_taken = ~a[31];
            link         = 1'b1;
          end
          default: branch_taken = 1'b0;
        endcase
      end
      OP_BEQ:  branch_taken = (a == b);
      OP_BNE:  branch_taken = (a != b);
      OP_BLEZ: branch_taken = a[31] | (a == 32'd0);
      OP_BGTZ: branch_taken = ~a[31] & (a != 32'd0);
      OP_ADDIU, OP_LB, OP_LH, OP_LWL, OP_LW,
      OP_LBU, OP_LHU, OP_LWR, OP_SB, OP_SH,
      OP_SWL, OP_SW: begin
        alu_out   = add_ai[31:0];
        carry_out = add_ai[32];
      end
      OP_SLTI:  alu_out = {31'd0, $signed(a) < $signed(sx)};
      OP_SLTIU: alu_out = {31'd0, a < sx};
      OP_ANDI:  alu_out = a & {16'd0, imm};
      OP_ORI:   alu_out = a | {16'd0, imm};
      OP_XORI:  alu_out = a ^ {16'd0, imm};
      OP_LUI:   alu_out = {imm, 16'd0};
      default:  alu_out = '0;
    endcase
  end

  assign zero = (alu_out == 32'd0);

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  logic        div_fin;
  logic [31:0] div_q;
  logic [31:0] div_r;

  mips_cpu_divider #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start && (funct == F_DIV || funct == F_DIVU)),
    .signed_op (funct == F_DIV),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .fin       (div_fin),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // HI/LO: division result wins; other writes locked out while busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (div_fin) begin
      hi <= div_r;
      lo <= div_q;
    end else if (hilo_en && !div_busy) begin
      case (funct)
        F_MULT:  {hi, lo} <= prod_s;
        F_MULTU: {hi, lo} <= prod_u;
        F_MTHI:  hi <= a;
        F_MTLO:  lo <= a;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_exec_datapath.sv
// Self-checking bench for the execute datapath:
// directed vectors, random ALU/regfile/HI-LO, divider timing.
module tb_mips_cpu_exec_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  wr_idx;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] register_v0;
  logic        carry_in;
  logic [31:0] alu_out;
  logic        carry_out;
  logic        zero;
  logic        branch_taken;
  logic        link;
  logic        hilo_en;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] hi;
  logic [31:0] lo;

  mips_cpu_exec_datapath dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .shamt(shamt), .imm(imm), .rs_idx(rs_idx), .rt_idx(rt_idx),
    .wr_idx(wr_idx), .wr_en(wr_en), .wr_data(wr_data),
    .rs_data(rs_data), .rt_data(rt_data),
    .register_v0(register_v0), .carry_in(carry_in),
    .alu_out(alu_out), .carry_out(carry_out), .zero(zero),
    .branch_taken(branch_taken), .link(link),
    .hilo_en(hilo_en), .div_start(div_start),
    .div_busy(div_busy), .div_done(div_done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] shadow [32];
  logic [31:0] mhi;
  logic [31:0] mlo;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    @(negedge clk);
    wr_idx = idx;
    wr_data = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
    if (idx != 5'd0) shadow[idx] = d;
  endtask

  // reference ALU: spec rules in plain integer arithmetic
  function automatic void model(
    input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
    input logic [4:0] rt, input logic [15:0] imm_v,
    input logic [31:0] av, input logic [31:0] bv, input logic cin,
    output logic [31:0] r, output logic c, output logic t, output logic l);
    longint ua = longint'({32'd0, av});
    longint ub = longint'({32'd0, bv});
    int sa = int'(av);
    int sb = int'(bv);
    int si = int'(shortint'(imm_v));
    logic [31:0] sxv = 32'(si);
    longint us = longint'({32'd0, sxv});
    r = 32'd0; c = cin; t = 1'b0; l = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h00: r = bv << sh;
        6'h02: r = bv >> sh;
        6'h03: r = 32'(sb >>> sh);
        6'h04: r = bv << av[4:0];
        6'h06: r = bv >> av[4:0];
        6'h07: r = 32'(sb >>> av[4:0]);
        6'h20, 6'h21: begin r = 32'(ua + ub); c = (ua + ub) >= 64'h1_0000_0000; end
        6'h22, 6'h23: begin r = av - bv; c = (av >= bv); end
        6'h24: r = av & bv;
        6'h25: r = av | bv;
        6'h26: r = av ^ bv;
        6'h27: r = ~(av | bv);
        6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
        6'h2B: r = (av < bv) ? 32'd1 : 32'd0;
        default: r = 32'd0;
      endcase
      6'h01: case (rt)
        5'd0:  t = sa < 0;
        5'd1:  t = sa >= 0;
        5'd16: begin t = sa < 0; l = 1'b1; end
        5'd17: begin t = sa >= 0; l = 1'b1; end
        default: t = 1'b0;
      endcase
      6'h04: t = (av == bv);
      6'h05: t = (av != bv);
      6'h06: t = (sa <= 0);
      6'h07: t = (sa > 0);
      6'h09, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
      6'h28, 6'h29, 6'h2A, 6'h2B: begin
        r = 32'(ua + us); c = (ua + us) >= 64'h1_0000_0000;
      end
      6'h0A: r = (sa < si) ? 32'd1 : 32'd0;
      6'h0B: r = (av < sxv) ? 32'd1 : 32'd0;
      6'h0C: r = av & {16'd0, imm_v};
      6'h0D: r = av | {16'd0, imm_v};
      6'h0E: r = av ^ {16'd0, imm_v};
      6'h0F: r = {imm_v, 16'd0};
      default: r = 32'd0;
    endcase
  endfunction

  function automatic void dmodel(input logic [5:0] fn, input logic [31:0] av,
    input logic [31:0] bv, output logic [31:0] q, output logic [31:0] r);
    longint x = longint'(int'(av));
    longint y = longint'(int'(bv));
    if (bv == 32'd0) begin
      q = 32'hFFFF_FFFF; r = av;
    end else if (fn == 6'h1B) begin
      q = av / bv; r = av % bv;
    end else begin
      q = 32'(x / y); r = 32'(x % y);
    end
  endfunction

  typedef struct {
    logic [5:0] op; logic [5:0] fn; logic [4:0] sh; logic [4:0] rt;
    logic [15:0] imm; logic [31:0] a; logic [31:0] b; logic cin;
    logic [31:0] alu; logic c; logic t; logic l;
  } vec_t;

  vec_t tv [16];

  task automatic apply(input logic [5:0] op, input logic [5:0] fn,
    input logic [4:0] sh, input logic [4:0] rt, input logic [15:0] im,
    input logic [31:0] av, input logic [31:0] bv, input logic cin);
    wr(5'd1, av);
    wr(5'd3, bv);
    opcode = op; funct = fn; shamt = sh; imm = im;
    rs_idx = 5'd1; rt_idx = rt; carry_in = cin;
    #1;
  endtask

  task automatic hop(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv);
    longint p;
    logic [63:0] pu;
    wr(5'd1, av);
    wr(5'd3, bv);
    @(negedge clk);
    opcode = 6'h00; funct = fn; rs_idx = 5'd1; rt_idx = 5'd3; hilo_en = 1'b1;
    @(posedge clk);
    #1 hilo_en = 1'b0;
    p = longint'(int'(av)) * longint'(int'(bv));
    pu = 64'(av) * 64'(bv);
    case (fn)
      6'h18: {mhi, mlo} = 64'(p);
      6'h19: {mhi, mlo} = pu;
      6'h11: mhi = av;
      default: mlo = av;
    endcase
    chk("hilo_hi", hi, mhi);
    chk("hilo_lo", lo, mlo);
  endtask

  task automatic run_div(input logic [5:0] fn, input logic [31:0] av,
    input logic [31:0] bv, input bit meddle);
    int cyc;
    logic [31:0] hi_before;
    logic [31:0] eq;
    logic [31:0] er;
    dmodel(fn, av, bv, eq, er);
    wr(5'd1, av);
    wr(5'd3, bv);
    @(negedge clk);
    opcode = 6'h00; funct = fn; rs_idx = 5'd1; rt_idx = 5'd3; div_start = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    chk("div_busy_start", div_busy, 1'b1);
    hi_before = hi;
    cyc = 0;
    while (!div_done && cyc < 40) begin
      if (meddle && cyc == 4) begin
        funct = 6'h1B; rs_idx = 5'd0; rt_idx = 5'd0; div_start = 1'b1;
      end
      if (meddle && cyc == 8) begin
        funct = 6'h11; rs_idx = 5'd3; hilo_en = 1'b1;
      end
      @(posedge clk);
      #1;
      div_start = 1'b0; hilo_en = 1'b0;
      funct = fn; rs_idx = 5'd1; rt_idx = 5'd3;
      cyc++;
      if (meddle && cyc == 9) chk("div_hilo_locked", hi, hi_before);
    end
    chk("div_latency", 64'(cyc), 64'd32);
    chk("div_lo", lo, eq);
    chk("div_hi", hi, er);
    chk("div_busy_end", div_busy, 1'b0);
    mhi = er; mlo = eq;
    @(posedge clk);
    #1 chk("div_done_pulse", div_done, 1'b0);
  endtask

  logic [5:0] ops [18] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h04, 6'h05,
    6'h06, 6'h07, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
    6'h23, 6'h2B, 6'h3F};
  logic [5:0] fns [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [4:0] rts [5] = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd9};

  initial begin
    logic [31:0] ea;
    logic ec, et, el;
    logic [31:0] av, bv;
    logic [5:0] op, fn;
    logic [4:0] sh, rt;
    logic [15:0] im;
    logic cin;

    tv[0]  = '{6'h00, 6'h23, 5'd0, 5'd3,  16'h0000, 32'd1, 32'd2, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{6'h00, 6'h03, 5'd4, 5'd3,  16'h0000, 32'd0, 32'h8000_0000, 1'b0, 32'hF800_0000, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{6'h0B, 6'h00, 5'd0, 5'd3,  16'hFFFF, 32'd5, 32'd0, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{6'h0F, 6'h00, 5'd0, 5'd3,  16'h1234, 32'd0, 32'd0, 1'b0, 32'h1234_0000, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{6'h01, 6'h00, 5'd0, 5'd16, 16'h0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1, 1'b1};
    tv[5]  = '{6'h07, 6'h00, 5'd0, 5'd3,  16'h0000, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{6'h00, 6'h21, 5'd0, 5'd3,  16'h0000, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{6'h06, 6'h00, 5'd0, 5'd3,  16'h0000, 32'd0, 32'd9, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0};
    tv[8]  = '{6'h00, 6'h2A, 5'd0, 5'd3,  16'h0000, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{6'h01, 6'h00, 5'd0, 5'd17, 16'h0000, 32'd5, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1};
    tv[10] = '{6'h01, 6'h00, 5'd0, 5'd16, 16'h0000, 32'd5, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1};
    tv[11] = '{6'h00, 6'h04, 5'd0, 5'd3,  16'h0000, 32'h24, 32'd1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0};
    tv[12] = '{6'h3F, 6'h00, 5'd0, 5'd3,  16'h0000, 32'd5, 32'd6, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0};
    tv[13] = '{6'h23, 6'h00, 5'd0, 5'd3,  16'hFFFC, 32'h1000, 32'd0, 1'b0, 32'h0FFC, 1'b1, 1'b0, 1'b0};
    tv[14] = '{6'h00, 6'h22, 5'd0, 5'd3,  16'h0000, 32'd5, 32'd3, 1'b0, 32'd2, 1'b1, 1'b0, 1'b0};
    tv[15] = '{6'h0D, 6'h00, 5'd0, 5'd3,  16'h8001, 32'hF000_0000, 32'd0, 1'b0, 32'hF000_8001, 1'b0, 1'b0, 1'b0};

    opcode = '0; funct = '0; shamt = '0; imm = '0;
    rs_idx = 5'd2; rt_idx = 5'd31; wr_idx = '0; wr_en = 1'b0;
    wr_data = '0; carry_in = 1'b0; hilo_en = 1'b0; div_start = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    mhi = 32'd0; mlo = 32'd0;
    reset = 1'b1;
    #12;
    chk("rst_rs", rs_data, 32'd0);
    chk("rst_rt", rt_data, 32'd0);
    chk("rst_v0", register_v0, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", div_busy, 1'b0);
    chk("rst_done", div_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    wr(5'd5, 32'd7);
    wr(5'd0, 32'd9);
    rs_idx = 5'd5; rt_idx = 5'd0;
    #1;
    chk("rf_rs5", rs_data, 32'd7);
    chk("rf_r0", rt_data, 32'd0);
    wr(5'd2, 32'hDEAD);
    #1 chk("rf_v0", register_v0, 32'hDEAD);
    @(negedge clk);
    wr_idx = 5'd5; wr_data = 32'd8; wr_en = 1'b1;
    #1 chk("rf_no_bypass", rs_data, 32'd7);
    @(posedge clk);
    #1 wr_en = 1'b0;
    shadow[5] = 32'd8;
    chk("rf_after_write", rs_data, 32'd8);

    for (int i = 0; i < 16; i++) begin
      apply(tv[i].op, tv[i].fn, tv[i].sh, tv[i].rt, tv[i].imm,
            tv[i].a, tv[i].b, tv[i].cin);
      chk($sformatf("vec%0d_alu", i), alu_out, tv[i].alu);
      chk($sformatf("vec%0d_carry", i), carry_out, tv[i].c);
      chk($sformatf("vec%0d_taken", i), branch_taken, tv[i].t);
      chk($sformatf("vec%0d_link", i), link, tv[i].l);
      chk($sformatf("vec%0d_zero", i), zero, tv[i].alu == 32'd0);
    end

    for (int k = 0; k < 300; k++) begin
      av = $urandom; bv = $urandom;
      if (k % 7 == 0) bv = av;
      if (k % 11 == 0) av = 32'd0;
      op = ops[$urandom_range(0, 17)];
      fn = (k % 2 == 0) ? fns[$urandom_range(0, 15)] : 6'($urandom);
      sh = 5'($urandom); im = 16'($urandom); cin = 1'($urandom);
      rt = (op == 6'h01) ? rts[$urandom_range(0, 4)] : 5'd3;
      apply(op, fn, sh, rt, im, av, bv, cin);
      model(op, fn, sh, rt, im, av, bv, cin, ea, ec, et, el);
      chk($sformatf("rnd_alu op=%h fn=%h", op, fn), alu_out, ea);
      chk($sformatf("rnd_carry op=%h fn=%h", op, fn), carry_out, ec);
      chk($sformatf("rnd_taken op=%h rt=%h", op, rt), branch_taken, et);
      chk($sformatf("rnd_link op=%h rt=%h", op, rt), link, el);
      chk("rnd_zero", zero, ea == 32'd0);
    end

    for (int k = 0; k < 40; k++) begin
      wr(5'($urandom), $urandom);
      rs_idx = 5'($urandom); rt_idx = 5'($urandom);
      #1;
      chk("rnd_rf_rs", rs_data, shadow[rs_idx]);
      chk("rnd_rf_rt", rt_data, shadow[rt_idx]);
      chk("rnd_rf_v0", register_v0, shadow[2]);
    end

    hop(6'h18, 32'hFFFF_FFFD, 32'd4);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFF4);
    hop(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);

    run_div(6'h1A, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);
    run_div(6'h1B, 32'd9, 32'd0, 1'b0);
    chk("divu_by0_lo", lo, 32'hFFFF_FFFF);
    chk("divu_by0_hi", hi, 32'd9);
    run_div(6'h1A, 32'd100, 32'd7, 1'b1);
    chk("div_meddle_lo", lo, 32'd14);
    chk("div_meddle_hi", hi, 32'd2);

    wr(5'd1, 32'hFFFF_FFF9);
    wr(5'd3, 32'd2);
    @(negedge clk);
    funct = 6'h1A; rs_idx = 5'd1; rt_idx = 5'd3; div_start = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("divrst_busy", div_busy, 1'b0);
    chk("divrst_done", div_done, 1'b0);
    chk("divrst_hi", hi, 32'd0);
    chk("divrst_lo", lo, 32'd0);
    chk("divrst_reg", rs_data, 32'd0);
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    mhi = 32'd0; mlo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("divrst_stays_idle", div_done, 1'b0);

    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 3))
        0: fn = 6'h18;
        1: fn = 6'h19;
        2: fn = 6'h11;
        default: fn = 6'h13;
      endcase
      hop(fn, $urandom, $urandom);
    end

    for (int k = 0; k < 8; k++) begin
      av = $urandom;
      case (k % 4)
        0: bv = 32'd0;
        1: bv = 32'($urandom_range(1, 20));
        2: bv = -32'($urandom_range(1, 20));
        default: bv = $urandom;
      endcase
      run_div((k % 3 == 0) ? 6'h1B : 6'h1A, av, bv, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
